// File: rtl/mouse_pkg.sv
// Shared constants and decode helpers for the Kempston mouse interface.
package mouse_pkg;

  // Which mouse register a Z80 read is aimed at, from A8/A10.
  typedef enum logic [1:0] {
    SEL_KEY  = 2'd0,
    SEL_X    = 2'd1,
    SEL_Y    = 2'd2,
    SEL_NONE = 2'd3
  } port_sel_e;

  // Partial port match: A0=A1=A7=1, A5=0, M1 high (not an opcode fetch).
  localparam logic PM_A0 = 1'b1;
  localparam logic PM_A1 = 1'b1;
  localparam logic PM_A7 = 1'b1;
  localparam logic PM_A5 = 1'b0;
  localparam logic PM_M1 = 1'b1;

  // KEY byte filler bits.
  localparam logic       KEY_RSVD_BIT = 1'b1;
  localparam logic       KEY_NO_BTN2  = 1'b1;
  localparam logic [3:0] KEY_NO_WHEEL = 4'hF;

  // Reset values.
  localparam logic [7:0] RST_X   = 8'h00;
  localparam logic [7:0] RST_Y   = 8'h00;
  localparam logic [3:0] RST_W   = 4'hF;
  localparam logic [2:0] RST_BTN = 3'b000;
  localparam logic [7:0] RST_D   = 8'hFF;

  function automatic port_sel_e decode_port(input logic a8, input logic a10);
    port_sel_e sel;
    case ({a10, a8})
      2'b00:   sel = SEL_KEY;
      2'b01:   sel = SEL_X;
      2'b11:   sel = SEL_Y;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mouse_upd_fifo.sv
// Synchronous first-word-fall-through FIFO for MCU motion updates.
module mouse_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mouse_controller_sync.sv
// Kempston mouse for ZX BUS: buffered MCU updates, X/Y/wheel accumulators,
// bus-synchronised snapshot register for #FADF/#FBDF/#FFDF reads.
module mouse_controller_sync
  import mouse_pkg::*;
#(
  parameter int unsigned DELTA_W     = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_BUTTONS = 3,
  parameter int unsigned WHEEL_EN    = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               UPD_VALID,
  output logic               UPD_READY,
  input  logic [DELTA_W-1:0] UPD_DX,
  input  logic [DELTA_W-1:0] UPD_DY,
  input  logic [3:0]         UPD_DW,
  input  logic [2:0]         UPD_BTN,
  input  logic               A0,
  input  logic               A1,
  input  logic               A5,
  input  logic               A7,
  input  logic               A8,
  input  logic               A10,
  input  logic               M1,
  input  logic               RD,
  input  logic               IORQ,
  output logic               IORQGE,
  output logic [7:0]         D,
  output logic               D_OE
);

  localparam int unsigned ENTRY_W = 2 * DELTA_W + 7;

  logic                      partial_match;
  logic                      bus_en;
  port_sel_e                 raw_sel;
  port_sel_e                 sync_sel;
  logic                      en_s1, en_s2, en_s3;
  logic                      a8_s1, a8_s2;
  logic                      a10_s1, a10_s2;
  logic                      en_rise;

  logic                      ready_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      do_pop;
  logic [ENTRY_W-1:0]        wr_entry;
  logic [ENTRY_W-1:0]        rd_entry;
  logic signed [DELTA_W-1:0] pop_dx;
  logic signed [DELTA_W-1:0] pop_dy;
  logic [3:0]                pop_dw;
  logic [2:0]                pop_btn;
  logic [7:0]                dx8;
  logic [7:0]                dy8;

  logic [7:0]                x_cnt;
  logic [7:0]                y_cnt;
  logic [3:0]                w_cnt;
  logic [2:0]                btn_q;
  logic [7:0]                key_byte;
  logic [7:0]                sel_value;
  logic [7:0]                d_q;

  // Raw-bus decode: IORQGE and D_OE react to the pins without any clock.
  assign partial_match = (A0 == PM_A0) & (A1 == PM_A1) & (A7 == PM_A7) &
                         (A5 == PM_A5) & (M1 == PM_M1);
  assign bus_en  = partial_match & ~RD & ~IORQ;
  assign raw_sel = decode_port(A8, A10);
  assign IORQGE  = ~partial_match;
  assign D_OE    = bus_en & (raw_sel != SEL_NONE);
  assign D       = d_q;

  // Two-flop synchroniser for the bus strobe and port select, plus edge history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_s1  <= 1'b0;
      en_s2  <= 1'b0;
      en_s3  <= 1'b0;
      a8_s1  <= 1'b0;
      a8_s2  <= 1'b0;
      a10_s1 <= 1'b0;
      a10_s2 <= 1'b0;
    end else begin
      en_s1  <= bus_en;
      en_s2  <= en_s1;
      en_s3  <= en_s2;
      a8_s1  <= A8;
      a8_s2  <= a8_s1;
      a10_s1 <= A10;
      a10_s2 <= a10_s1;
    end
  end

  assign en_rise  = en_s2 & ~en_s3;
  assign sync_sel = decode_port(a8_s2, a10_s2);

  // Ready is held low during reset and comes up on the first clock after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign UPD_READY = ready_q & ~fifo_full;
  assign fifo_push = UPD_VALID & UPD_READY;
  assign fifo_pop  = ~en_s2;
  assign do_pop    = fifo_pop & ~fifo_empty;
  assign wr_entry  = {UPD_BTN, UPD_DW, UPD_DY, UPD_DX};
  assign {pop_btn, pop_dw, pop_dy, pop_dx} = rd_entry;

  // Signed size cast sign-extends narrow deltas and truncates wide ones.
  assign dx8 = 8'(pop_dx);
  assign dy8 = 8'(pop_dy);

  mouse_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Accumulate one update per clock; frozen while a synced bus read is active.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_cnt <= RST_X;
      y_cnt <= RST_Y;
      w_cnt <= RST_W;
      btn_q <= RST_BTN;
    end else if (do_pop) begin
      x_cnt <= x_cnt + dx8;
      y_cnt <= y_cnt + dy8;
      w_cnt <= w_cnt + pop_dw;
      btn_q <= pop_btn;
    end
  end

  // KEY byte: wheel nibble, reserved bit, active-low buttons.
  always_comb begin
    key_byte = {KEY_NO_WHEEL, KEY_RSVD_BIT, KEY_NO_BTN2, ~btn_q[1], ~btn_q[0]};
    if (WHEEL_EN != 0)    key_byte[7:4] = w_cnt;
    if (NUM_BUTTONS == 3) key_byte[2]   = ~btn_q[2];
  end

  // Register selected by the synchronised address; undecoded keeps the old snapshot.
  always_comb begin
    case (sync_sel)
      SEL_KEY: sel_value = key_byte;
      SEL_X:   sel_value = x_cnt;
      SEL_Y:   sel_value = y_cnt;
      default: sel_value = d_q;
    endcase
  end

  // Snapshot loads once per read, on the rising edge of the synced strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          d_q <= RST_D;
    else if (en_rise) d_q <= sel_value;
  end

endmodule
